// File: rtl/mprj_ckpt_pkg.sv
// Shared definitions for the checkpoint monitor.
//   ckpt_state_e  : sequencer state encoding (IDLE=0, ARMED=1, DONE=2)
//   ckpt_result_e : result code held while in DONE; each code maps to
//                   exactly one of the pass / fail_timeout / fail_order flags.
package mprj_ckpt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } ckpt_state_e;

  typedef enum logic [1:0] {
    RES_NONE    = 2'd0,
    RES_PASS    = 2'd1,
    RES_TIMEOUT = 2'd2,
    RES_ORDER   = 2'd3
  } ckpt_result_e;

endpackage

// File: rtl/ckpt_stable_filter.sv
// Consecutive-match qualifier. Counts cycles on which 'match' is true and
// flags 'hit' on the cycle that completes STABLE_CYCLES consecutive matches.
// The count restarts after every hit, so a signature that stays on the bus
// must be re-qualified from scratch to produce another hit.
// Ports:
//   clock, resetb : clock and asynchronous active-low reset
//   en            : counting enabled (run in progress); counter held at 0 otherwise
//   clr           : synchronous counter clear
//   match         : comparison result for this cycle
//   hit           : combinational, match held for STABLE_CYCLES cycles
module ckpt_stable_filter #(
  parameter int STABLE_CYCLES = 1
) (
  input  logic clock,
  input  logic resetb,
  input  logic en,
  input  logic clr,
  input  logic match,
  output logic hit
);

  localparam int            SW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] LAST = SW'(STABLE_CYCLES - 1);

  logic [SW-1:0] stab;

  assign hit = en && match && (stab == LAST);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      stab <= '0;
    end else if (clr || !en || !match || hit) begin
      stab <= '0;
    end else begin
      stab <= stab + SW'(1);
    end
  end

endmodule

// File: rtl/mprj_checkpoint_monitor.sv
// Checkpoint sequencer for user-project self-test. Firmware drives a
// checkpoint field onto checkbits; the monitor expects the programmed
// signatures in table order, each held for STABLE_CYCLES samples, within
// TIMEOUT_CYCLES cycles of start.
// Ports:
//   clock, resetb          : clock, asynchronous active-low reset
//   checkbits              : observed checkpoint field
//   cfg_we/cfg_addr/cfg_data : signature table write (ignored while busy)
//   cfg_len, strict        : run length and out-of-order check, latched at start
//   start, clear           : arm a run / synchronous return to idle
//   busy, done             : run in progress / run finished (held)
//   pass, fail_timeout, fail_order : result flags, exactly one set in DONE
//   ckpt_idx               : checkpoints hit so far
//   hit_cycle, cycle_cnt   : cycle stamp of the latest hit / run cycle count
module mprj_checkpoint_monitor
  import mprj_ckpt_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int NUM_CKPT       = 4,
  parameter int STABLE_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 70000,
  localparam int AW    = $clog2(NUM_CKPT),
  localparam int IW    = AW + 1,
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic [WIDTH-1:0] checkbits,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic [IW-1:0]    cfg_len,
  input  logic             strict,
  input  logic             start,
  input  logic             clear,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail_timeout,
  output logic             fail_order,
  output logic [IW-1:0]    ckpt_idx,
  output logic [CNT_W-1:0] hit_cycle,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  function automatic logic [IW-1:0] clamp_len(input logic [IW-1:0] v);
    if (v == '0)                  return IW'(1);
    else if (int'(v) > NUM_CKPT)  return IW'(NUM_CKPT);
    else                          return v;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  ckpt_state_e      state_q, state_d;
  ckpt_result_e     result_q, result_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    len_q, len_d;
  logic             strict_q, strict_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hit_q, hit_d;

  logic [WIDTH-1:0] sig_table [NUM_CKPT];
  logic [WIDTH-1:0] checkbits_p0;
  logic [WIDTH-1:0] cur_sig;
  logic             armed;
  logic             cur_match, cur_hit;
  logic             any_later, ooo_match, ooo_hit;
  logic             last_entry, timeout_edge;

  assign armed = (state_q == ST_ARMED);

  // Signature table: writable only outside a run so the expected sequence
  // cannot change under an active check. Cleared by reset only.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < NUM_CKPT; i++) sig_table[i] <= '0;
    end else if (cfg_we && !armed && (int'(cfg_addr) < NUM_CKPT)) begin
      sig_table[cfg_addr] <= cfg_data;
    end
  end

  // ---- stage p0: sample the checkpoint field ----
  always_ff @(posedge clock) begin
    checkbits_p0 <= checkbits;
  end

  // ---- compare sampled field against the table ----
  always_comb begin
    cur_sig = '0;
    if (int'(idx_q) < NUM_CKPT) cur_sig = sig_table[idx_q[AW-1:0]];
  end

  assign cur_match = (checkbits_p0 == cur_sig);

  // Any entry strictly after the current one, within the active length.
  always_comb begin
    any_later = 1'b0;
    for (int j = 0; j < NUM_CKPT; j++) begin
      if ((j > int'(idx_q)) && (j < int'(len_q)) && (checkbits_p0 == sig_table[j]))
        any_later = 1'b1;
    end
  end

  assign ooo_match = strict_q && !cur_match && any_later;

  ckpt_stable_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_cur_filter (
    .clock  (clock),
    .resetb (resetb),
    .en     (armed),
    .clr    (clear),
    .match  (cur_match),
    .hit    (cur_hit)
  );

  ckpt_stable_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_ooo_filter (
    .clock  (clock),
    .resetb (resetb),
    .en     (armed),
    .clr    (clear),
    .match  (ooo_match),
    .hit    (ooo_hit)
  );

  assign last_entry   = ((idx_q + IW'(1)) == len_q);
  assign timeout_edge = (cnt_q == TO_LAST);

  // Next-state and result logic. The cycle counter advances on every ARMED
  // edge that stays ARMED; the edge that ends the run leaves it at its value,
  // so a timeout reports TIMEOUT_CYCLES-1 and a pass reports the hit cycle.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    idx_d    = idx_q;
    len_d    = len_q;
    strict_d = strict_q;
    cnt_d    = cnt_q;
    hit_d    = hit_q;

    if (clear) begin
      state_d  = ST_IDLE;
      result_d = RES_NONE;
      idx_d    = '0;
      len_d    = '0;
      strict_d = 1'b0;
      cnt_d    = '0;
      hit_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d  = ST_ARMED;
            result_d = RES_NONE;
            idx_d    = '0;
            cnt_d    = '0;
            hit_d    = '0;
            len_d    = clamp_len(cfg_len);
            strict_d = strict;
          end
        end
        ST_ARMED: begin
          if (cur_hit) begin
            idx_d = idx_q + IW'(1);
            hit_d = cnt_q;
          end
          if (cur_hit && last_entry) begin
            state_d  = ST_DONE;
            result_d = RES_PASS;
          end else if (ooo_hit) begin
            state_d  = ST_DONE;
            result_d = RES_ORDER;
          end else if (timeout_edge) begin
            state_d  = ST_DONE;
            result_d = RES_TIMEOUT;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q  <= ST_IDLE;
      result_q <= RES_NONE;
      idx_q    <= '0;
      len_q    <= '0;
      strict_q <= 1'b0;
      cnt_q    <= '0;
      hit_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      strict_q <= strict_d;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
    end
  end

  assign busy         = armed;
  assign done         = (state_q == ST_DONE);
  assign pass         = (result_q == RES_PASS);
  assign fail_timeout = (result_q == RES_TIMEOUT);
  assign fail_order   = (result_q == RES_ORDER);
  assign ckpt_idx     = idx_q;
  assign hit_cycle    = hit_q;
  assign cycle_cnt    = cnt_q;

endmodule
